invader_bomb: RTL and testbench

- Manages the invaders' downward projectiles, the return direction of the player's laser.
- A frame-counted fire timer picks a column from an LFSR and requests the lowest live invader in that column from the invader grid.
- On a grant, spawns a bomb in a free slot. Each frame, every active bomb moves down until it hits the player or leaves the screen.
- Sits between the invader grid, the player-collision logic and the renderer.

---
 rtl/invader_bomb.sv | 152 +++++++++++++++
 tb/tb_invader_bomb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/invader_bomb.sv
// invader_bomb: fire timer, shooter request handshake and per-slot bomb
// movement for the invaders' downward projectiles.
module invader_bomb #(
  parameter int NUM_BOMBS           = 3,
  parameter int NUM_COLS            = 11,
  parameter int BOMB_STEP           = 4,
  parameter int SCREEN_BOTTOM       = 480,
  parameter int FIRE_INTERVAL       = 32,
  parameter int SPRITE_WIDTH_SCALED = 32,
  parameter int SPRITE_HEIGHT_SCALED = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame,
  input  logic                     fire_en,
  output logic                     fire_req,
  output logic [3:0]               col_sel,
  input  logic                     shooter_valid,
  input  logic                     shooter_none,
  input  logic [9:0]               shooter_x,
  input  logic [9:0]               shooter_y,
  input  logic [NUM_BOMBS-1:0]     bomb_hit,
  output logic [NUM_BOMBS-1:0]     bomb_active,
  output logic [10*NUM_BOMBS-1:0]  bomb_x,
  output logic [10*NUM_BOMBS-1:0]  bomb_y
);

  localparam int CNT_W = $clog2(FIRE_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIRE_INTERVAL - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           lfsr_q;
  logic                 lfsr_fb;
  logic                 fire_req_d;
  logic [3:0]           col_sel_d;
  logic                 spawn;
  logic [NUM_BOMBS-1:0] first_free;
  logic                 slot_found;
  logic [10:0]          y_sum [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] y_off;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Lowest-index slot that is free at the start of this cycle (one-hot).
  always_comb begin
    first_free = '0;
    slot_found = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (!slot_found && !bomb_active[i]) begin
        first_free[i] = 1'b1;
        slot_found    = 1'b1;
      end
    end
  end

  // Next y per slot, widened by one bit so the off-screen test cannot wrap.
  always_comb begin
    for (int i = 0; i < NUM_BOMBS; i++) begin
      y_sum[i] = {1'b0, bomb_y[10*i +: 10]} + 11'(BOMB_STEP);
      y_off[i] = (y_sum[i] >= 11'(SCREEN_BOTTOM));
    end
  end

  // Fire-timer FSM: counts frames in IDLE, then holds a request until the grid replies.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fire_req_d = fire_req;
    col_sel_d  = col_sel;
    spawn      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fire_en) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX && slot_found) begin
          state_d    = REQ;
          cnt_d      = '0;
          fire_req_d = 1'b1;
          col_sel_d  = 4'(lfsr_q % 8'(NUM_COLS));
        end else if (frame && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ: begin
        if (!fire_en) begin
          state_d    = IDLE;
          cnt_d      = '0;
          fire_req_d = 1'b0;
        end else if (shooter_valid) begin
          state_d    = IDLE;
          fire_req_d = 1'b0;
          spawn      = slot_found;
        end else if (shooter_none) begin
          state_d    = IDLE;
          fire_req_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        fire_req_d = 1'b0;
      end
    endcase
  end

  // Control registers: FSM state, frame counter, free-running LFSR and request outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lfsr_q   <= 8'hA5;
      fire_req <= 1'b0;
      col_sel  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= {lfsr_q[6:0], lfsr_fb};
      fire_req <= fire_req_d;
      col_sel  <= col_sel_d;
    end
  end

  // Bomb slots: spawn on grant, retire on hit or screen exit, otherwise fall each frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bomb_active <= '0;
      bomb_x      <= '0;
      bomb_y      <= '0;
    end else begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        if (spawn && first_free[i]) begin
          bomb_active[i]      <= 1'b1;
          bomb_x[10*i +: 10]  <= shooter_x + 10'(SPRITE_WIDTH_SCALED / 2);
          bomb_y[10*i +: 10]  <= shooter_y + 10'(SPRITE_HEIGHT_SCALED);
        end else if (bomb_active[i]) begin
          if (bomb_hit[i]) begin
            bomb_active[i] <= 1'b0;
          end else if (frame) begin
            if (y_off[i]) begin
              bomb_active[i] <= 1'b0;
            end else begin
              bomb_y[10*i +: 10] <= y_sum[i][9:0];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_invader_bomb.sv
// tb_invader_bomb: directed and randomized stimulus checked every cycle
// against a behavioural model of the bomb manager.
module tb_invader_bomb;

  localparam int NB = 3;
  localparam int FI = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame = 1'b0;
  logic          fire_en = 1'b0;
  logic          shooter_valid = 1'b0;
  logic          shooter_none = 1'b0;
  logic [9:0]    shooter_x = '0;
  logic [9:0]    shooter_y = '0;
  logic [NB-1:0] bomb_hit = '0;
  logic          fire_req;
  logic [3:0]    col_sel;
  logic [NB-1:0] bomb_active;
  logic [10*NB-1:0] bomb_x;
  logic [10*NB-1:0] bomb_y;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: request outstanding flag, frame count, slots as ints.
  bit         m_req;
  int         m_cnt;
  int         m_col;
  logic [7:0] m_lfsr;
  bit         m_act [NB];
  int         m_x [NB];
  int         m_y [NB];

  always #5 clk = ~clk;

  invader_bomb #(
    .NUM_BOMBS(NB), .NUM_COLS(11), .BOMB_STEP(4), .SCREEN_BOTTOM(480),
    .FIRE_INTERVAL(FI), .SPRITE_WIDTH_SCALED(32), .SPRITE_HEIGHT_SCALED(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .fire_en(fire_en),
    .fire_req(fire_req), .col_sel(col_sel),
    .shooter_valid(shooter_valid), .shooter_none(shooter_none),
    .shooter_x(shooter_x), .shooter_y(shooter_y),
    .bomb_hit(bomb_hit), .bomb_active(bomb_active),
    .bomb_x(bomb_x), .bomb_y(bomb_y)
  );

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic modelStep();
    int g;
    if (!rst_n) begin
      m_req = 0; m_cnt = 0; m_col = 0; m_lfsr = 8'hA5;
      for (int i = 0; i < NB; i++) begin
        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      return;
    end
    g = -1;
    if (!m_req) begin
      bit any_free;
      any_free = 0;
      for (int i = 0; i < NB; i++) if (!m_act[i]) any_free = 1;
      if (!fire_en) m_cnt = 0;
      else if (m_cnt == FI - 1 && any_free) begin
        m_req = 1; m_cnt = 0; m_col = int'(m_lfsr) % 11;
      end else if (frame && m_cnt < FI - 1) m_cnt++;
    end else begin
      if (!fire_en) begin
        m_req = 0; m_cnt = 0;
      end else if (shooter_valid) begin
        m_req = 0;
        for (int i = NB - 1; i >= 0; i--) if (!m_act[i]) g = i;
      end else if (shooter_none) m_req = 0;
    end
    for (int i = 0; i < NB; i++) begin
      if (i == g) begin
        m_act[i] = 1;
        m_x[i] = (int'(shooter_x) + 16) % 1024;
        m_y[i] = (int'(shooter_y) + 32) % 1024;
      end else if (m_act[i]) begin
        if (bomb_hit[i]) m_act[i] = 0;
        else if (frame) begin
          if (m_y[i] + 4 >= 480) m_act[i] = 0;
          else m_y[i] = m_y[i] + 4;
        end
      end
    end
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  // Compare every DUT output with the model.
  task automatic checkAll();
    logic [NB-1:0]    ea;
    logic [10*NB-1:0] ex, ey;
    for (int i = 0; i < NB; i++) begin
      ea[i] = m_act[i];
      ex[10*i +: 10] = 10'(m_x[i]);
      ey[10*i +: 10] = 10'(m_y[i]);
    end
    checkOutput("fire_req", 32'(fire_req), 32'(m_req));
    checkOutput("col_sel", 32'(col_sel), 32'(m_col));
    checkOutput("bomb_active", 32'(bomb_active), 32'(ea));
    checkOutput("bomb_x", 32'(bomb_x), 32'(ex));
    checkOutput("bomb_y", 32'(bomb_y), 32'(ey));
  endtask

  // Drive one cycle of inputs, clock it, update the model and check.
  task automatic applyStimulus(input bit r, input bit f, input bit e, input bit v, input bit n,
                               input logic [9:0] sx, input logic [9:0] sy, input logic [NB-1:0] h);
    @(negedge clk);
    rst_n = r; frame = f; fire_en = e; shooter_valid = v; shooter_none = n;
    shooter_x = sx; shooter_y = sy; bomb_hit = h;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  initial begin
    logic [NB-1:0] act_snap;
    bit v, n;

    // Reset and first fire interval.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, '0);
    checkOutput("rst_fire_req", 32'(fire_req), 0);
    checkOutput("rst_active", 32'(bomb_active), 0);
    checkOutput("rst_bomb_y", 32'(bomb_y), 0);
    for (int k = 0; k < FI - 1; k++) applyStimulus(1, 1, 1, 0, 0, 0, 0, '0);
    checkOutput("no_early_req", 32'(fire_req), 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, '0);
    checkOutput("req_after_interval", 32'(fire_req), 1);
    checkOutput("col_range", 32'(col_sel < 4'd11), 1);

    // Grant with a known shooter position.
    applyStimulus(1, 0, 1, 1, 0, 10'd100, 10'd200, '0);
    checkOutput("spawn_active", 32'(bomb_active), 1);
    checkOutput("spawn_x", 32'(bomb_x[9:0]), 116);
    checkOutput("spawn_y", 32'(bomb_y[9:0]), 232);
    checkOutput("spawn_req_drop", 32'(fire_req), 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, '0);
    checkOutput("move_y", 32'(bomb_y[9:0]), 236);

    // Long-held request aborted by fire_en dropping, with a late reply ignored.
    for (int k = 0; k < 4 * FI && !m_req; k++) applyStimulus(1, 1, 1, 0, 0, 0, 0, '0);
    checkOutput("reached_req", 32'(fire_req), 1);
    for (int k = 0; k < 10; k++) applyStimulus(1, 0, 1, 0, 0, 0, 0, '0);
    act_snap = bomb_active;
    applyStimulus(1, 0, 0, 1, 0, 10'd50, 10'd50, '0);
    checkOutput("abort_req", 32'(fire_req), 0);
    checkOutput("abort_no_spawn", 32'(bomb_active), 32'(act_snap));

    // Empty column reply restarts the full interval.
    for (int k = 0; k < 4 * FI && !m_req; k++) applyStimulus(1, 1, 1, 0, 0, 0, 0, '0);
    act_snap = bomb_active;
    applyStimulus(1, 0, 1, 0, 1, 10'd60, 10'd60, '0);
    checkOutput("none_no_spawn", 32'(bomb_active), 32'(act_snap));
    for (int k = 0; k < FI - 2; k++) applyStimulus(1, 1, 1, 0, 0, 0, 0, '0);
    checkOutput("none_restart", 32'(fire_req), 0);

    // Randomized traffic including hits, coincident replies and rare resets.
    for (int k = 0; k < 4000; k++) begin
      v = 0; n = 0;
      if (m_req && ($urandom % 3 == 0)) begin
        case ($urandom % 8)
          0, 1:    n = 1;
          2:       begin v = 1; n = 1; end
          default: v = 1;
        endcase
      end
      applyStimulus(($urandom % 600) != 0, ($urandom % 3) == 0, ($urandom % 40) != 0, v, n,
                    10'($urandom), 10'($urandom),
                    NB'((($urandom % 12) == 0) ? $urandom : 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
